// File: rtl/bram_playback_pkg.sv
// Shared types and sizing helpers for the BRAM playback reader.
package bram_playback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Two extra slots beyond the BRAM latency cover the issue->pop->credit return loop.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/bram_playback_reader_sample_fifo.sv
// Synchronous FIFO whose head lives in an output register; the ring holds the
// remaining DEPTH-1 entries so total capacity equals DEPTH.
module sample_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int RING = DEPTH - 1;
    localparam int PW   = (RING > 1) ? $clog2(RING) : 1;
    localparam int CW   = $clog2(RING + 1);

    logic [WIDTH-1:0] ring_q [RING];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_free, load_ring, load_wr, push_ring;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_free  = !out_valid_q || rd_ready_i;
    assign load_ring = out_free && (count_q != '0);
    // A write bypasses the ring only when the ring is empty, preserving order.
    assign load_wr   = out_free && (count_q == '0) && wr_en_i;
    assign push_ring = wr_en_i && !load_wr;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (out_free) begin
            out_valid_d = load_ring || load_wr;
            if (load_ring) begin
                out_data_d = ring_q[rd_ptr_q];
            end else if (load_wr) begin
                out_data_d = wr_data_i;
            end
        end
        if (push_ring) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (load_ring) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ring, load_ring})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ring) begin
            ring_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_valid_o = out_valid_q;
    assign rd_data_o  = out_data_q;

endmodule

// File: rtl/bram_playback_reader.sv
// Streams BRAM words 0..last_addr onto an AXI-Stream master, optionally looping,
// with a credit counter sized so the output FIFO can never overflow.
module bram_playback_reader
    import bram_playback_pkg::*;
#(
    parameter int  DATA_WIDTH   = 18,
    parameter int  BRAM_DEPTH   = 1024,
    parameter int  READ_LATENCY = 3,
    localparam int AW           = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [AW-1:0]         last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [AW-1:0]         bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    localparam int FD = fifo_depth(READ_LATENCY);
    localparam int CW = $clog2(FD + 1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d, last_q, last_d;
    logic                    loop_q, loop_d;
    logic [CW-1:0]           credits_q, credits_d;
    logic [READ_LATENCY-1:0] tag_valid_q, tag_last_q;
    logic                    issue, handshake;
    logic [DATA_WIDTH:0]     fifo_dout;

    // Stream handshake: a beat transfers in any cycle with m_tvalid & m_tready high;
    // m_tdata/m_tlast hold steady while m_tvalid is high and m_tready is low.
    assign issue     = (state_q == RUN) && (credits_q < CW'(FD));
    assign handshake = m_tvalid && m_tready;
    assign bram_en   = issue;
    assign bram_addr = issue ? addr_q : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN) && (credits_q == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = '0;
                    last_d  = last_addr;
                    loop_d  = loop_en;
                end
            end
            RUN: begin
                if (issue) begin
                    if (addr_q == last_q) begin
                        addr_d = '0;
                        if (!loop_q) state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (credits_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case ({issue, handshake})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            credits_q   <= '0;
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            last_q         <= last_d;
            loop_q         <= loop_d;
            credits_q      <= credits_d;
            // Tags ride alongside the BRAM pipeline so its output can be qualified.
            tag_valid_q[0] <= issue;
            tag_last_q[0]  <= (addr_q == last_q);
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
        end
    end

    sample_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FD)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (tag_valid_q[READ_LATENCY-1]),
        .wr_data_i  ({tag_last_q[READ_LATENCY-1], bram_dout}),
        .rd_ready_i (m_tready),
        .rd_valid_o (m_tvalid),
        .rd_data_o  (fifo_dout)
    );

    assign {m_tlast, m_tdata} = fifo_dout;

endmodule
